// File: rtl/i2s_pkg.sv
// Shared types and default-rate constants for the I2S clock sequencer.
package i2s_pkg;

    typedef enum logic [1:0] {IDLE, START, RUN, STOP} i2s_clk_state_t;

    localparam int I2S_MCLK_HZ = 12288000;
    localparam int I2S_FS      = 48000;

    // Master clocks per bit clock for a stereo frame of 2*frame_bits bits.
    function automatic int sclk_div_calc(input int mclk_hz, input int fs, input int frame_bits);
        return mclk_hz / (fs * 2 * frame_bits);
    endfunction

endpackage

// File: rtl/i2s_rd_watchdog.sv
// Fifo read-response watchdog: flags reads not answered within RD_TIMEOUT clocks.
// The saturating underrun counter is built only when I2S_UNDERRUN_CNT_EN is defined.
module i2s_rd_watchdog #(
    parameter int RD_TIMEOUT = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic             rd_valid,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_count
);

    localparam int WD_W = $clog2(RD_TIMEOUT + 1);

    logic            armed;
    logic [WD_W-1:0] wd_cnt;
    logic            expire;

    // A new request or a response in the terminal cycle wins over the timeout.
    assign expire = armed && !rd_en && !rd_valid && (wd_cnt == WD_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed    <= 1'b0;
            wd_cnt   <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= expire;
            if (rd_en && rd_valid) begin
                armed  <= 1'b0;
                wd_cnt <= '0;
            end else if (rd_en) begin
                armed  <= 1'b1;
                wd_cnt <= WD_W'(RD_TIMEOUT);
            end else if (rd_valid) begin
                armed  <= 1'b0;
                wd_cnt <= '0;
            end else if (armed) begin
                wd_cnt <= wd_cnt - 1'b1;
                if (expire)
                    armed <= 1'b0;
            end
        end
    end

`ifdef I2S_UNDERRUN_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (expire && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

    assign underrun_count = cnt;
`else
    assign underrun_count = '0;
`endif

endmodule

// File: rtl/i2s_clk_ctrl.sv
// I2S master clock/frame sequencer: derives sclk/lrclk from clk and stops on frame boundaries.
// Optional underrun counter enabled by defining I2S_UNDERRUN_CNT_EN.
//
// state | meaning
// IDLE  | parked, sclk=0 lrclk=1, waiting for en
// START | one cycle, counters cleared
// RUN   | clocking frames, en=0 requests a stop
// STOP  | clocking until the right half-frame ends, then IDLE
module i2s_clk_ctrl
    import i2s_pkg::*;
#(
    parameter int FRAME_BITS = 32,
    parameter int SCLK_DIV   = sclk_div_calc(I2S_MCLK_HZ, I2S_FS, FRAME_BITS),
    parameter int RD_TIMEOUT = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             sclk,
    output logic             lrclk,
    output logic             frame_start,
    output logic             active,
    input  logic             rd_en,
    input  logic             rd_valid,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_count
);

    localparam int DIV_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(2 * FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(FRAME_BITS);

    i2s_clk_state_t   state;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [BIT_W-1:0] bit_nxt;
    logic             div_wrap;
    logic             bit_wrap;

    assign div_wrap = (div_cnt == DIV_MAX);
    assign bit_wrap = div_wrap && (bit_cnt == BIT_MAX);
    assign div_nxt  = div_wrap ? '0 : div_cnt + 1'b1;
    assign bit_nxt  = (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;

    assign active = (state == RUN) || (state == STOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            sclk        <= 1'b0;
            lrclk       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    sclk    <= 1'b0;
                    lrclk   <= 1'b1;
                    if (en)
                        state <= START;
                end
                START: begin
                    // Left-channel edge lands on the first RUN cycle.
                    div_cnt     <= '0;
                    bit_cnt     <= '0;
                    sclk        <= 1'b0;
                    lrclk       <= 1'b0;
                    frame_start <= 1'b1;
                    state       <= RUN;
                end
                RUN, STOP: begin
                    div_cnt <= div_nxt;
                    sclk    <= (div_nxt >= DIV_HALF);
                    if (div_wrap) begin
                        bit_cnt     <= bit_nxt;
                        lrclk       <= (bit_nxt >= BIT_HALF);
                        frame_start <= bit_wrap;
                    end
                    if (state == RUN) begin
                        if (!en)
                            state <= STOP;
                    end else if (bit_wrap) begin
                        // Frame complete: park without starting a new left half.
                        state       <= IDLE;
                        lrclk       <= 1'b1;
                        frame_start <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    i2s_rd_watchdog #(
        .RD_TIMEOUT (RD_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_rd_watchdog (
        .clk            (clk),
        .rst            (rst),
        .rd_en          (rd_en),
        .rd_valid       (rd_valid),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

endmodule
